// File: rtl/acia_6502_if.sv
// CPU-side bus bundle for the acia_6502 UART peripheral.
// The CPU (or testbench) uses the master modport; the peripheral uses slave.
interface acia_6502_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, we, addr, din, input dout, irq);
  modport slave  (input cs, we, addr, din, output dout, irq);
endinterface

// File: rtl/acia_6502.sv
// acia_6502: memory-mapped 8N1 UART for the 6502 bus.
//   addr 0 DATA   : read pops RX byte (clears RXF), write loads TX holding reg
//   addr 1 STATUS : [7]=irq [4]=FIFO full [3]=FE [2]=OVR [1]=TXE [0]=RXF,
//                   any write clears OVR and FE
//   addr 2 CTRL   : [0]=RXIE [1]=TXIE
//   addr 3        : reads 0, writes ignored
// Optional build macro ACIA_RX_FIFO_EN replaces the single RX holding register
// with a 4-entry FIFO (STATUS[4] reports full; reads 0 without the FIFO).
module acia_6502 #(
  parameter int CLK_DIV = 35,
  parameter int DIV_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  acia_6502_if.slave   bus,
  input  logic         rx,
  output logic         tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);

  // ---------------------------------------------------------------- bus decode
  logic rd, rd_data, wr_data, wr_status, wr_ctrl;

  assign rd        = bus.cs & ~bus.we;
  assign rd_data   = rd & (bus.addr == 2'd0);
  assign wr_data   = bus.cs & bus.we & (bus.addr == 2'd0);
  assign wr_status = bus.cs & bus.we & (bus.addr == 2'd1);
  assign wr_ctrl   = bus.cs & bus.we & (bus.addr == 2'd2);

  // ------------------------------------------------------------------- TX path
  ser_state_t       tx_state, tx_state_next;
  logic [DIV_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift, tx_hold;
  logic             txe, tx_load, tx_bit_end;

  assign tx_bit_end = (tx_cnt == DIV_LAST);

  // TX next-state logic; tx pin is decoded from state so reset forces it high at once
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    tx            = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!txe) begin
          tx_load       = 1'b1;
          tx_state_next = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_state_next = S_DATA;
      end
      S_DATA: begin
        tx = tx_shift[0];
        if (tx_bit_end && tx_bit == 3'd7) tx_state_next = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_end) tx_state_next = S_IDLE;
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers are assigned with <= so every flop samples pre-edge values.
    if (!reset) tx_state <= S_IDLE;
    else        tx_state <= tx_state_next;
  end

  // TX bit timer and shifter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_cnt <= (tx_state == S_IDLE || tx_bit_end) ? '0 : tx_cnt + DIV_W'(1);
      if (tx_load) begin
        tx_shift <= tx_hold;
        tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_bit_end) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // TX holding register: a write is only accepted while it is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_hold <= '0;
      txe     <= 1'b1;
    end else if (tx_load) begin
      txe <= 1'b1;
    end else if (wr_data && txe) begin
      tx_hold <= bus.din;
      txe     <= 1'b0;
    end
  end

  // ------------------------------------------------------------------- RX path
  ser_state_t       rx_state, rx_state_next;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_meta, rx_sync;
  logic             rx_start_ok, rx_abort, rx_shift_en, rx_done, rx_frame_err;

  // Two-flop synchronizer for the asynchronous rx pin (idles high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX next-state logic: mid-start check, then one sample per bit period
  always_comb begin
    rx_state_next = rx_state;
    rx_start_ok   = 1'b0;
    rx_abort      = 1'b0;
    rx_shift_en   = 1'b0;
    rx_done       = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (!rx_sync) rx_state_next = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          if (rx_sync) begin
            rx_abort      = 1'b1;
            rx_state_next = S_IDLE;
          end else begin
            rx_start_ok   = 1'b1;
            rx_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_shift_en = 1'b1;
          if (rx_bit == 3'd7) rx_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt == DIV_LAST) begin
          rx_done       = 1'b1;
          rx_state_next = S_IDLE;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  assign rx_frame_err = rx_done & ~rx_sync;

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= S_IDLE;
    else        rx_state <= rx_state_next;
  end

  // RX sample timer and shifter (LSB arrives first)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == S_IDLE || rx_start_ok || rx_abort || rx_shift_en || rx_done)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + DIV_W'(1);
      if (rx_start_ok) begin
        rx_bit <= '0;
      end else if (rx_shift_en) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ------------------------------------------------------------ RX byte storage
  logic [7:0] rd_byte;
  logic       rxf, rx_full, rx_ovr_evt;

`ifdef ACIA_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;

  assign pop        = rd_data & (count != 3'd0);
  assign rx_ovr_evt = rx_done & (count == 3'd4) & ~pop;
  assign push       = rx_done & ~rx_ovr_evt;
  assign rxf        = (count != 3'd0);
  assign rx_full    = (count == 3'd4);
  assign rd_byte    = fifo_mem[rd_ptr];

  // FIFO storage array
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; count/pointers guard every entry before it is read.
    if (push) fifo_mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] rx_data;
  logic       rx_push;

  // A byte landing on the same edge as a DATA read is not an overrun
  assign rx_ovr_evt = rx_done & rxf & ~rd_data;
  assign rx_push    = rx_done & ~rx_ovr_evt;
  assign rx_full    = 1'b0;
  assign rd_byte    = rx_data;

  // Single-byte RX holding register; the old byte wins on overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rxf     <= 1'b0;
    end else if (rx_push) begin
      rx_data <= rx_shift;
      rxf     <= 1'b1;
    end else if (rd_data) begin
      rxf <= 1'b0;
    end
  end
`endif

  // ------------------------------------------------------- status, ctrl, irq
  logic ovr, fe, rxie, txie, irq_q;
  logic [7:0] dout_q;

  // Error flags: a new error on the same edge as a STATUS write is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr <= 1'b0;
      fe  <= 1'b0;
    end else begin
      if (wr_status) begin
        ovr <= 1'b0;
        fe  <= 1'b0;
      end
      if (rx_ovr_evt)   ovr <= 1'b1;
      if (rx_frame_err) fe  <= 1'b1;
    end
  end

  // Interrupt enables and the registered level interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxie  <= 1'b0;
      txie  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rxie <= bus.din[0];
        txie <= bus.din[1];
      end
      irq_q <= (rxie & rxf) | (txie & txe);
    end
  end

  // Registered read data, valid the cycle after the address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else if (rd) begin
      case (bus.addr)
        2'd0:    dout_q <= rd_byte;
        2'd1:    dout_q <= {irq_q, 2'b00, rx_full, fe, ovr, txe, rxf};
        2'd2:    dout_q <= {6'b0, txie, rxie};
        default: dout_q <= 8'h00;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_acia_6502.sv
// Testbench for acia_6502: directed bus/serial stimulus, read-data scoreboard
// and a serial TX frame monitor, both decoupled from the stimulus process.
module tb_acia_6502;

  localparam int CLK_DIV = 35;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  acia_6502_if bus ();

  acia_6502 #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  byte unsigned exp_q[$];
  string        name_q[$];
  byte unsigned tx_q[$];
  bit           tx_mon_en = 1'b1;
  logic         rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ bus drivers
  // Each task is entered at a negedge and returns at the following negedge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial RX frame; stop_low drives a bad stop bit for most of the bit period
  task automatic send_rx(input logic [7:0] b, input bit stop_low);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    if (stop_low) begin
      rx = 1'b0;
      repeat (CLK_DIV * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CLK_DIV - CLK_DIV * 3 / 4) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------- read-data scoreboard
  always @(posedge clk) rd_seen <= reset & bus.cs & ~bus.we;

  byte unsigned mon_exp;
  string        mon_name;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL read monitor: got 0x%0h, expected no read", bus.dout);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, bus.dout, mon_exp);
      end
    end
  end

  // -------------------------------------------------------- TX frame monitor
  initial begin : tx_monitor
    logic         prev;
    int           first_high, k;
    logic [7:0]   got;
    logic         start_mid, stop_bit;
    byte unsigned e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && tx_mon_en && prev && !tx) begin
        first_high = -1; got = '0; start_mid = 1'b1; stop_bit = 1'b0;
        for (int c = 1; c <= CLK_DIV * 9 + CLK_DIV / 2; c++) begin
          @(negedge clk);
          if (first_high < 0 && tx) first_high = c;
          if (c == CLK_DIV / 2) begin
            start_mid = tx;
          end else if (c > CLK_DIV / 2 && (c - CLK_DIV / 2) % CLK_DIV == 0) begin
            k = (c - CLK_DIV / 2) / CLK_DIV;
            if (k <= 8) got[k-1] = tx;
            else        stop_bit = tx;
          end
        end
        if (tx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx monitor: got frame 0x%0h, expected none", got);
        end else begin
          e = tx_q.pop_front();
          check("tx frame byte", got, e);
          check("tx start bit", start_mid, 1'b0);
          check("tx stop bit", stop_bit, 1'b1);
          if (e[0]) check("tx start width", first_high, CLK_DIV);
        end
      end
      prev = tx;
    end
  end

  // ------------------------------------------------------- global watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stim
    int bad;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.din = 8'h00;

    // Reset values
    idle(3);
    check("reset tx", tx, 1'b1);
    check("reset irq", bus.irq, 1'b0);
    check("reset dout", bus.dout, 8'h00);
    reset = 1'b1;
    idle(2);
    bus_read(2'd1, 8'h02, "status after reset");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.irq !== 1'b0) bad++;
    end
    check("idle tx/irq 100 cycles", bad, 0);

    // TX: A5, a dropped write while busy loading, then 5A queued behind it
    tx_q.push_back(8'hA5);
    bus_write(2'd0, 8'hA5);
    bus_write(2'd0, 8'hFF);
    check("tx start on load", tx, 1'b0);
    bus_read(2'd1, 8'h02, "status TXE back after load");
    tx_q.push_back(8'h5A);
    bus_write(2'd0, 8'h5A);
    bus_read(2'd1, 8'h00, "status TXE low while held");
    bad = 0;
    while (tx_q.size() != 0 && bad < 1500) begin
      @(negedge clk);
      bad++;
    end
    check("tx frames drained", tx_q.size(), 0);
    idle(10);

    // Unmapped register and CTRL
    bus_read(2'd3, 8'h00, "addr3 read");
    bus_write(2'd3, 8'hFF);
    bus_read(2'd3, 8'h00, "addr3 after write");
    bus_write(2'd2, 8'hFF);
    idle(1);
    check("irq from TXIE", bus.irq, 1'b1);
    bus_read(2'd1, 8'h82, "status with irq");
    bus_read(2'd2, 8'h03, "ctrl readback");
    bus_write(2'd2, 8'h00);
    idle(1);
    check("irq off after ctrl clear", bus.irq, 1'b0);

    // RX single byte
    send_rx(8'h3C, 1'b0);
    bus_read(2'd1, 8'h03, "status RXF set");
    bus_read(2'd0, 8'h3C, "rx data 3C");
    bus_read(2'd1, 8'h02, "status RXF cleared");

    // RX interrupt
    bus_write(2'd2, 8'h01);
    idle(2);
    check("irq before rx", bus.irq, 1'b0);
    send_rx(8'h55, 1'b0);
    check("irq after rx", bus.irq, 1'b1);
    bus_read(2'd0, 8'h55, "rx data 55");
    check("irq on read edge", bus.irq, 1'b1);
    @(negedge clk);
    check("irq dropped after read", bus.irq, 1'b0);
    bus_write(2'd2, 8'h00);

    // Overrun
`ifdef ACIA_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0);
    bus_read(2'd1, 8'h17, "status fifo full+ovr");
    for (int i = 1; i <= 4; i++) bus_read(2'd0, 8'(i), "fifo pop");
    bus_read(2'd1, 8'h06, "status fifo empty ovr");
`else
    send_rx(8'h11, 1'b0);
    send_rx(8'h22, 1'b0);
    bus_read(2'd1, 8'h07, "status overrun");
    bus_read(2'd0, 8'h11, "rx keeps old byte");
    bus_read(2'd1, 8'h06, "status ovr after read");
`endif
    bus_write(2'd1, 8'h00);
    bus_read(2'd1, 8'h02, "status ovr cleared");

    // Framing error
    send_rx(8'h81, 1'b1);
    idle(40);
    bus_read(2'd1, 8'h0B, "status framing error");
    bus_read(2'd0, 8'h81, "rx data with FE");
    bus_write(2'd1, 8'h00);
    bus_read(2'd1, 8'h02, "status FE cleared");

    // Idle-line glitch
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(100);
    bus_read(2'd1, 8'h02, "status after glitch");

    // Reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    bus_write(2'd0, 8'h00);
    idle(50);
    check("tx low mid-frame", tx, 1'b0);
    #2 reset = 1'b0;
    #1 check("tx high on async reset", tx, 1'b1);
    idle(3);
    reset = 1'b1;
    idle(2);
    bus_read(2'd1, 8'h02, "status after mid-frame reset");
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("frame lost after reset", bad, 0);

    idle(3);
    check("read scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
